// File: rtl/fx2_in_arbiter.sv
// fx2_in_arbiter: shares the FX2 slave-FIFO write path between the sample
// stream (EP6) and the command-reply stream (EP8). One byte moves per grant,
// so the peak rate is one byte every two cycles. PKTEND is issued for reply
// frames and for stale partial sample packets. Everything is in fx2_clk.
module fx2_in_arbiter #(
    parameter logic [1:0]  SAMPLE_EP    = 2'b10,
    parameter logic [1:0]  REPLY_EP     = 2'b11,
    parameter int unsigned BURST_MAX    = 64,
    parameter int unsigned PKT_SIZE     = 512,
    parameter int unsigned FLUSH_CYCLES = 4096
) (
    input  logic       fx2_clk,
    input  logic       rst_n,
    input  logic       sample_rdy,
    input  logic [7:0] sample,
    output logic       sample_ack,
    input  logic       reply_rdy,
    input  logic [7:0] reply,
    input  logic       reply_end,
    output logic       reply_ack,
    input  logic       fifo_full_n,
    output logic [1:0] fifoadr,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic       pktend
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int CW = $clog2(PKT_SIZE);
    localparam int TW = $clog2(FLUSH_CYCLES);

    localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);
    localparam logic [CW-1:0] PKT_LAST   = CW'(PKT_SIZE - 1);
    localparam logic [TW-1:0] FLUSH_LAST = TW'(FLUSH_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_REPLY  = 3'd2;
    localparam logic [2:0] S_REPEND = 3'd3;
    localparam logic [2:0] S_TURN   = 3'd4;
    localparam logic [2:0] S_FLUSH  = 3'd5;

    logic [2:0]    state_q,      state_d;
    logic [2:0]    target_q,     target_d;   // state to enter after TURN
    logic [1:0]    fifoadr_q,    fifoadr_d;
    logic          wr_en_q,      wr_en_d;
    logic [7:0]    wr_data_q,    wr_data_d;
    logic          sample_ack_q, sample_ack_d;
    logic          reply_ack_q,  reply_ack_d;
    logic          pktend_q,     pktend_d;
    logic [BW-1:0] burst_q,      burst_d;
    logic [CW-1:0] cnt_q,        cnt_d;      // bytes in the current sample packet
    logic [TW-1:0] idle_q,       idle_d;     // idle cycles with a partial packet

    // Next-state, grant and counter logic for the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        fifoadr_d    = fifoadr_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        sample_ack_d = 1'b0;
        reply_ack_d  = 1'b0;
        pktend_d     = 1'b0;
        burst_d      = burst_q;
        cnt_d        = cnt_q;
        idle_d       = '0;
        case (state_q)
            S_IDLE: begin
                if (reply_rdy) begin
                    state_d  = S_TURN;
                    target_d = S_REPLY;
                end else if (sample_rdy) begin
                    state_d = S_SAMPLE;
                    burst_d = '0;
                end else if (cnt_q != '0) begin
                    if (idle_q == FLUSH_LAST) begin
                        // Commit the stale partial packet, switching EP first if needed.
                        if (fifoadr_q == SAMPLE_EP) begin
                            state_d = S_FLUSH;
                        end else begin
                            state_d  = S_TURN;
                            target_d = S_FLUSH;
                        end
                    end else begin
                        idle_d = idle_q + TW'(1);
                    end
                end else begin
                    idle_d = '0;
                end
            end
            S_SAMPLE: begin
                if (reply_rdy && (burst_q == BURST_LIM)) begin
                    state_d  = S_TURN;
                    target_d = S_REPLY;
                end else if (!sample_rdy) begin
                    state_d = S_IDLE;
                end else if (fifo_full_n && !wr_en_q) begin
                    wr_en_d      = 1'b1;
                    wr_data_d    = sample;
                    sample_ack_d = 1'b1;
                    // The FX2 auto-commits at the packet boundary, so just wrap.
                    if (cnt_q == PKT_LAST) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (burst_q == BURST_LIM) begin
                        burst_d = burst_q;
                    end else begin
                        burst_d = burst_q + BW'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_REPLY: begin
                if (reply_rdy && fifo_full_n && !wr_en_q) begin
                    wr_en_d     = 1'b1;
                    wr_data_d   = reply;
                    reply_ack_d = 1'b1;
                    if (reply_end) begin
                        state_d = S_REPEND;
                    end else begin
                        state_d = S_REPLY;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_REPEND: begin
                // Every reply frame is committed explicitly, even a full one.
                pktend_d = 1'b1;
                state_d  = S_TURN;
                target_d = S_IDLE;
            end
            S_TURN: begin
                // fifoadr moves here so it is settled a cycle before any strobe.
                if (target_q == S_REPLY) begin
                    fifoadr_d = REPLY_EP;
                end else begin
                    fifoadr_d = SAMPLE_EP;
                end
                state_d = target_q;
            end
            S_FLUSH: begin
                pktend_d = 1'b1;
                cnt_d    = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops everything at once, mid-frame included.
    always_ff @(posedge fx2_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            target_q     <= S_IDLE;
            fifoadr_q    <= SAMPLE_EP;
            wr_en_q      <= 1'b0;
            wr_data_q    <= 8'h00;
            sample_ack_q <= 1'b0;
            reply_ack_q  <= 1'b0;
            pktend_q     <= 1'b0;
            burst_q      <= '0;
            cnt_q        <= '0;
            idle_q       <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            fifoadr_q    <= fifoadr_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            sample_ack_q <= sample_ack_d;
            reply_ack_q  <= reply_ack_d;
            pktend_q     <= pktend_d;
            burst_q      <= burst_d;
            cnt_q        <= cnt_d;
            idle_q       <= idle_d;
        end
    end

    assign fifoadr    = fifoadr_q;
    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign sample_ack = sample_ack_q;
    assign reply_ack  = reply_ack_q;
    assign pktend     = pktend_q;

endmodule

// File: tb/tb_fx2_in_arbiter.sv
// Bench for fx2_in_arbiter: a cycle table for reply/sample handshakes, then
// scripted sequences for flush timing, burst limit, stall, wrap and reset.
module tb_fx2_in_arbiter;

    logic       fx2_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_rdy = 1'b0;
    logic [7:0] sample = 8'h00;
    logic       sample_ack;
    logic       reply_rdy = 1'b0;
    logic [7:0] reply = 8'h00;
    logic       reply_end = 1'b0;
    logic       reply_ack;
    logic       fifo_full_n = 1'b1;
    logic [1:0] fifoadr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       pktend;

    fx2_in_arbiter dut (
        .fx2_clk(fx2_clk), .rst_n(rst_n),
        .sample_rdy(sample_rdy), .sample(sample), .sample_ack(sample_ack),
        .reply_rdy(reply_rdy), .reply(reply), .reply_end(reply_end), .reply_ack(reply_ack),
        .fifo_full_n(fifo_full_n), .fifoadr(fifoadr), .wr_en(wr_en),
        .wr_data(wr_data), .pktend(pktend)
    );

    always #5 fx2_clk = ~fx2_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- table of cycle vectors ----------------
    typedef struct packed {
        logic       sr;
        logic [7:0] sd;
        logic       rr;
        logic [7:0] rd;
        logic       re;
        logic [13:0] exp;   // {fifoadr, wr_en, wr_data, pktend, sample_ack, reply_ack}
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t v(input logic sr, input logic [7:0] sd, input logic rr,
                               input logic [7:0] rd, input logic re, input logic [1:0] fa,
                               input logic we, input logic [7:0] wd, input logic pk,
                               input logic sa, input logic ra);
        vec_t t;
        t.sr = sr; t.sd = sd; t.rr = rr; t.rd = rd; t.re = re;
        t.exp = {fa, we, wd, pk, sa, ra};
        return t;
    endfunction

    function automatic logic [13:0] outs();
        return {fifoadr, wr_en, (wr_en ? wr_data : 8'h00), pktend, sample_ack, reply_ack};
    endfunction

    // ---------------- monitor and sources ----------------
    int cyc, s_wr, r_wr, pk_cnt, pk_cyc, last_s_cyc, min_gap, max_gap, viol, order_err, s_before_r;
    logic [1:0] pk_ep;
    logic [1:0] prev_fa;
    logic [7:0] exp_s;
    logic [7:0] s_val = 8'h00;
    logic [7:0] r_got [$];
    int s_left = 0;
    int r_len = 0;
    int r_idx = 0;

    task automatic clr_mon();
        cyc = 0; s_wr = 0; r_wr = 0; pk_cnt = 0; pk_cyc = 0; last_s_cyc = 0;
        min_gap = 1000000; max_gap = 0; viol = 0; order_err = 0; s_before_r = -1;
        pk_ep = 2'b00; prev_fa = fifoadr; exp_s = s_val; r_got.delete();
    endtask

    // One clock: observe outputs after the edge, then let the sources react to acks.
    task automatic tick();
        int gap;
        @(posedge fx2_clk);
        #1;
        cyc++;
        if (wr_en) begin
            if (fifoadr == 2'b10) begin
                if (wr_data !== exp_s) order_err++;
                exp_s = exp_s + 8'h01;
                if (s_wr > 0) begin
                    gap = cyc - last_s_cyc;
                    if (gap < min_gap) min_gap = gap;
                    if (gap > max_gap) max_gap = gap;
                end
                last_s_cyc = cyc;
                s_wr++;
            end else begin
                r_got.push_back(wr_data);
                if (r_wr == 0) s_before_r = s_wr;
                r_wr++;
            end
        end
        if (pktend) begin
            pk_cnt++;
            pk_ep = fifoadr;
            pk_cyc = cyc;
        end
        if ((wr_en || pktend) && (fifoadr !== prev_fa)) viol++;
        if (sample_ack !== (wr_en && fifoadr == 2'b10)) viol++;
        if (reply_ack !== (wr_en && fifoadr == 2'b11)) viol++;
        prev_fa = fifoadr;
        if (sample_ack) begin
            s_val = s_val + 8'h01;
            s_left--;
            sample = s_val;
            if (s_left <= 0) sample_rdy = 1'b0;
        end
        if (reply_ack) begin
            r_idx++;
            if (r_idx >= r_len) begin
                reply_rdy = 1'b0;
                reply_end = 1'b0;
            end else begin
                reply = 8'(8'hA0 + r_idx);
                reply_end = (r_idx == r_len - 1);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_rdy = 1'b0; reply_rdy = 1'b0; reply_end = 1'b0; fifo_full_n = 1'b1;
        s_left = 0; r_len = 0; r_idx = 0;
        repeat (2) @(posedge fx2_clk);
        #1;
        rst_n = 1'b1;
        clr_mon();
    endtask

    task automatic start_s(input int n);
        s_left = n;
        sample = s_val;
        sample_rdy = 1'b1;
    endtask

    task automatic start_r(input int n);
        r_len = n;
        r_idx = 0;
        reply = 8'hA0;
        reply_end = (n == 1);
        reply_rdy = 1'b1;
    endtask

    task automatic run_until_s(input int target, input int budget, input string name);
        int k = 0;
        while (s_wr < target && k < budget) begin
            tick();
            k++;
        end
        chk(name, s_wr, target);
    endtask

    initial begin
        int k;
        int bad;
        // reply 3 bytes from IDLE, then two samples, then reply-vs-sample tie
        tbl[0]  = v(1'b0, 8'h00, 1'b1, 8'hA1, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[1]  = v(1'b0, 8'h00, 1'b1, 8'hA1, 1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[2]  = v(1'b0, 8'h00, 1'b1, 8'hA1, 1'b0, 2'b11, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1);
        tbl[3]  = v(1'b0, 8'h00, 1'b1, 8'hA2, 1'b0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[4]  = v(1'b0, 8'h00, 1'b1, 8'hA2, 1'b0, 2'b11, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1);
        tbl[5]  = v(1'b0, 8'h00, 1'b1, 8'hA3, 1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[6]  = v(1'b0, 8'h00, 1'b1, 8'hA3, 1'b1, 2'b11, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1);
        tbl[7]  = v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tbl[8]  = v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[9]  = v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[10] = v(1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[11] = v(1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 2'b10, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        tbl[12] = v(1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[13] = v(1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 2'b10, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        tbl[14] = v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[15] = v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[16] = v(1'b1, 8'h33, 1'b1, 8'hB1, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[17] = v(1'b1, 8'h33, 1'b1, 8'hB1, 1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[18] = v(1'b1, 8'h33, 1'b1, 8'hB1, 1'b1, 2'b11, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1);
        tbl[19] = v(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 2'b11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tbl[20] = v(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[21] = v(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[22] = v(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 2'b10, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        tbl[23] = v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset state, with wr_data unmasked.
        do_reset();
        chk("reset_outputs", {fifoadr, wr_en, wr_data, pktend, sample_ack, reply_ack},
            {2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});

        // Table: reply frame from IDLE, sample handshakes, reply wins a tie.
        for (int i = 0; i < 24; i++) begin
            sample_rdy = tbl[i].sr;
            sample     = tbl[i].sd;
            reply_rdy  = tbl[i].rr;
            reply      = tbl[i].rd;
            reply_end  = tbl[i].re;
            @(posedge fx2_clk);
            #1;
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // 10 samples, then a flush after 4096 idle cycles.
        do_reset();
        start_s(10);
        run_until_s(10, 100, "t1_writes");
        chk("t1_min_gap", min_gap, 2);
        chk("t1_max_gap", max_gap, 2);
        k = 0;
        while (pk_cnt == 0 && k < 6000) begin
            tick();
            k++;
        end
        chk("t1_flush_pktend", pk_cnt, 1);
        chk("t1_flush_delay", pk_cyc - last_s_cyc, 4098);
        chk("t1_flush_ep", pk_ep, 2'b10);
        repeat (5000) tick();
        chk("t1_count_cleared", pk_cnt, 1);
        chk("t1_order", order_err, 0);
        chk("t1_protocol", viol, 0);

        // Continuous samples; reply raised at byte 5 waits for the burst limit.
        do_reset();
        start_s(200);
        run_until_s(5, 50, "t3_first5");
        start_r(3);
        run_until_s(100, 600, "t3_resume");
        chk("t3_samples_before_reply", s_before_r, 64);
        chk("t3_reply_count", r_wr, 3);
        if (r_got.size() == 3) begin
            chk("t3_reply_bytes", {r_got[0], r_got[1], r_got[2]}, 24'hA0A1A2);
        end else begin
            chk("t3_reply_bytes_size", r_got.size(), 3);
        end
        chk("t3_reply_pktend", pk_cnt, 1);
        chk("t3_reply_pktend_ep", pk_ep, 2'b11);
        chk("t3_order", order_err, 0);
        chk("t3_protocol", viol, 0);
        sample_rdy = 1'b0;
        s_left = 0;

        // FIFO full for 20 cycles mid-stream.
        do_reset();
        start_s(30);
        run_until_s(8, 50, "t4_first8");
        fifo_full_n = 1'b0;
        bad = 0;
        repeat (20) begin
            tick();
            if (wr_en || sample_ack || reply_ack) bad++;
        end
        fifo_full_n = 1'b1;
        chk("t4_stall_quiet", bad, 0);
        run_until_s(30, 200, "t4_writes");
        chk("t4_order", order_err, 0);
        chk("t4_protocol", viol, 0);

        // 512 samples wrap the packet count: no flush afterwards.
        do_reset();
        start_s(512);
        run_until_s(512, 1200, "t5_writes");
        repeat (5000) tick();
        chk("t5_no_flush", pk_cnt, 0);
        chk("t5_order", order_err, 0);
        chk("t5_protocol", viol, 0);

        // Reset while reply byte 2 is on the bus.
        do_reset();
        start_r(3);
        k = 0;
        while (r_wr < 2 && k < 50) begin
            tick();
            k++;
        end
        chk("t6_reached_byte2", r_wr, 2);
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", {fifoadr, wr_en, wr_data, pktend, sample_ack, reply_ack},
            {2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        sample_rdy = 1'b0; reply_rdy = 1'b0; reply_end = 1'b0; r_len = 0;
        repeat (2) @(posedge fx2_clk);
        #1;
        rst_n = 1'b1;
        clr_mon();
        repeat (3) tick();
        chk("t6_quiet_after_reset", s_wr + r_wr + pk_cnt, 0);
        start_s(1);
        tick();
        tick();
        chk("t6_idle_sample_latency", s_wr, 1);
        chk("t6_no_reply", r_wr, 0);
        chk("t6_protocol", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
